// File: rtl/demux2_stream.sv
// demux2_stream: registered 1-to-2 stream demultiplexer.
// One N-bit word per cycle on a valid/ready input is steered by sel into one
// of two one-entry output registers, each drained independently by its sink.
// Optional build macro: DEMUX2_COUNT_EN adds per-channel 16-bit accept
// counters on ports count0/count1.

// One output channel: a single-entry register with an EMPTY/FULL FSM.
module demux2_chan #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_i,     // accept targeted at this channel
  input  logic [N-1:0] data_i,
  input  logic         ready_i,  // sink takes the word this cycle
  output logic [N-1:0] y_o,
  output logic         valid_o
`ifdef DEMUX2_COUNT_EN
  ,
  output logic [15:0]  count_o
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state_q;
  logic [N-1:0] data_q;

  // Load on accept (takes priority over drain so FULL->FULL streams at full
  // rate); otherwise a FULL channel empties when its sink is ready. The data
  // register is left untouched on drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else if (wr_i) begin
      state_q <= FULL;
      data_q  <= data_i;
    end else if (state_q == FULL && ready_i) begin
      state_q <= EMPTY;
    end
  end

  assign y_o     = data_q;
  assign valid_o = (state_q == FULL);

`ifdef DEMUX2_COUNT_EN
  logic [15:0] count_q;

  // Words accepted into this channel; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else if (wr_i) count_q <= count_q + 16'd1;
  end

  assign count_o = count_q;
`endif

endmodule

// Top level: steering, in_ready and the two channel instances.
module demux2_stream #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         sel,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic [N-1:0] y0,
  output logic         y0_valid,
  input  logic         y0_ready,
  output logic [N-1:0] y1,
  output logic         y1_valid,
  input  logic         y1_ready
`ifdef DEMUX2_COUNT_EN
  ,
  output logic [15:0]  count0,
  output logic [15:0]  count1
`endif
);

  localparam int NCH = 2;

  logic                    accept;
  logic [NCH-1:0]          wr;
  logic [NCH-1:0]          ch_ready;
  logic [NCH-1:0]          ch_valid;
  logic [NCH-1:0][N-1:0]   ch_y;
`ifdef DEMUX2_COUNT_EN
  logic [NCH-1:0][15:0]    ch_cnt;
`endif

  assign ch_ready = {y1_ready, y0_ready};

  // Only the selected channel gates the input; no fall-through to the other
  // channel, and no dependence on in_valid.
  assign in_ready = enable & (~ch_valid[sel] | ch_ready[sel]);
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign wr[k] = accept & (sel == (k == 1));

    demux2_chan #(.N(N)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (wr[k]),
      .data_i  (in_data),
      .ready_i (ch_ready[k]),
      .y_o     (ch_y[k]),
      .valid_o (ch_valid[k])
`ifdef DEMUX2_COUNT_EN
      ,
      .count_o (ch_cnt[k])
`endif
    );
  end

  assign y0       = ch_y[0];
  assign y1       = ch_y[1];
  assign y0_valid = ch_valid[0];
  assign y1_valid = ch_valid[1];

`ifdef DEMUX2_COUNT_EN
  assign count0 = ch_cnt[0];
  assign count1 = ch_cnt[1];
`endif

endmodule
